sram_1rw1r_masked: RTL
======================

# sram_1rw1r_masked

Parametrised behavioural SRAM macro model with one read/write port and one read-only port, per-byte write mask, spare-column write enable, a selectable 1- or 2-cycle read pipeline and a hardware zero-clear sequencer after reset. It replaces fixed-size single-port models in the systolic-array buffer path, where the weight/activation loader writes through port 0 while the array drains through port 1.

## Interface

Parameters:
- DATA_WIDTH, 32, data bits per word; multiple of 8
- ADDR_WIDTH, 6, address bits; RAM_DEPTH = 1 << ADDR_WIDTH
- NUM_WMASKS, DATA_WIDTH/8, byte-mask width (derived, not overridden)
- READ_LATENCY, 1, posedge-to-data cycles, legal values 1 or 2
- WRITE_FIRST, 1, same-address collision policy: 1 = port 1 returns new data, 0 = old data

Ports:
- clk0  in  1  clock, all logic on posedge
- rst0  in  1  synchronous active-high reset
- csb0  in  1  port 0 active-low chip select
- web0  in  1  port 0 active-low write enable
- wmask0  in  NUM_WMASKS  per-byte write enable, bit i covers din0[8i+7:8i]
- spare_wen0  in  1  write enable for spare bit din0[DATA_WIDTH]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH+1  write data, MSB is spare column
- dout0  out  DATA_WIDTH+1  port 0 read data
- dout0_valid  out  1  port 0 read data valid, one-cycle pulse
- csb1  in  1  port 1 active-low chip select (read only)
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH+1  port 1 read data
- dout1_valid  out  1  port 1 read data valid, one-cycle pulse
- init_done  out  1  high once clear sequence completes
- collision  out  1  one-cycle pulse: port 0 write and port 1 read hit same address

## Operation

- Sequencer states: CLEAR, READY. Reset forces CLEAR with clear pointer 0.
- CLEAR: one word per cycle written to all-zero (data and spare); pointer increments; after word RAM_DEPTH-1 go to READY. Port requests ignored, no valid pulses, collision held 0.
- READY: port 0 write (csb0=0, web0=0): bytes with wmask0[i]=1 updated, others unchanged; spare bit updated only if spare_wen0=1. wmask0 all-zero with spare_wen0=0 is a legal no-op.
- Port 0 read (csb0=0, web0=1): word addr0 returned on dout0.
- Port 1 read (csb1=0): word addr1 returned on dout1.
- Collision (port 0 write, port 1 read, addr0==addr1): collision=1 next cycle; dout1 = merged post-write word if WRITE_FIRST=1, pre-write word if 0. Port 0 reading while port 1 reads the same address is not a collision.
- Outputs hold last read value when no read issued; only *_valid marks new data.
- Reset mid-operation: in-flight reads dropped (valids 0), memory re-cleared, init_done drops.

## Timing

- Reset values: dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, init_done=0, collision=0.
- All inputs sampled on posedge; write visible to any read issued the following cycle.
- init_done rises on the posedge RAM_DEPTH cycles after the first cycle with rst0=0 (64 cycles at default), stays high until next reset.
- Read latency: request at edge N, data and valid registered at edge N+READ_LATENCY; fully pipelined, one read per port per cycle, back-to-back reads give consecutive valid pulses.
- collision pulse aligned to request edge +1 regardless of READ_LATENCY.
- No combinational path from any input to any output.

## Test plan

- Reset, release, idle 64 cycles -> init_done rises exactly at cycle 64; read addr 5 afterwards returns 0 with dout1_valid one pulse.
- Write addr 3 din0=0x1_DEADBEEF, wmask0=4'b1111, spare_wen0=1; later wmask0=4'b0010, din0=0x0_00005500, spare_wen0=0 -> read addr 3 returns 0x1_DEAD55EF.
- Same-cycle port 0 write 0xA5A5A5A5 to addr 9 (old 0x12345678) and port 1 read addr 9 -> collision=1; dout1=0xA5A5A5A5 with WRITE_FIRST=1, 0x12345678 with WRITE_FIRST=0.
- READ_LATENCY=2, port 1 reads addr 0,1,2 on consecutive cycles -> three consecutive dout1_valid pulses starting 2 cycles after first request, data in order.
- Requests issued during CLEAR (write addr 7 = 0xFFFFFFFF) -> no valid pulses, addr 7 reads 0 after init_done.
- Assert rst0 with a read in flight and after writing addr 4 -> valid suppressed, init_done low, addr 4 reads 0 after new clear.

Source files
------------

// File: rtl/sram_1rw1r_masked.sv
// Behavioural 1RW + 1R SRAM macro model with byte write mask, spare column,
// 1- or 2-cycle read pipeline and a post-reset zero-clear sequencer.
module sram_1rw1r_masked #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1,
  parameter bit WRITE_FIRST  = 1'b1,
  localparam int NUM_WMASKS  = DATA_WIDTH / 8
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [NUM_WMASKS-1:0]   wmask0,
  input  logic                    spare_wen0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH:0]     din0,
  output logic [DATA_WIDTH:0]     dout0,
  output logic                    dout0_valid,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH:0]     dout1,
  output logic                    dout1_valid,
  output logic                    init_done,
  output logic                    collision
);

  localparam int WORD_W    = DATA_WIDTH + 1;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    clr_we;

  logic [WORD_W-1:0]       mem [RAM_DEPTH];
  logic [WORD_W-1:0]       wr_word;
  logic                    ready, wr_en, rd0_en, rd1_en, collide;

  // First pipeline stage: memory sampled on the request edge.
  logic                    s_v0, s_v1, s_col;
  logic [WORD_W-1:0]       s_d0, s_d1;
  // Last pipeline stage before the output registers.
  logic                    p_v0, p_v1;
  logic [WORD_W-1:0]       p_d0, p_d1;

  // Sequencer
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (clr_we) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    clr_we     = 1'b0;
    if (state == CLEAR) begin
      clr_we = 1'b1;
      if (clr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) state_next = READY;
    end
  end

  assign init_done = (state == READY);
  assign ready     = (state == READY);
  assign wr_en     = ready && !csb0 && !web0;
  assign rd0_en    = ready && !csb0 && web0;
  assign rd1_en    = ready && !csb1;
  assign collide   = wr_en && rd1_en && (addr0 == addr1);

  // Post-write word: masked bytes and optional spare bit merged over the stored word.
  always_comb begin
    wr_word = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) wr_word[8*i +: 8] = din0[8*i +: 8];
    end
    if (spare_wen0) wr_word[DATA_WIDTH] = din0[DATA_WIDTH];
  end

  // NOTE: the array has no reset; contents are zeroed by the clear sequencer instead.
  always_ff @(posedge clk0) begin
    if (clr_we)     mem[clr_ptr] <= '0;
    else if (wr_en) mem[addr0]   <= wr_word;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      s_v0  <= 1'b0;
      s_v1  <= 1'b0;
      s_col <= 1'b0;
      s_d0  <= '0;
      s_d1  <= '0;
    end else begin
      s_v0  <= rd0_en;
      s_v1  <= rd1_en;
      s_col <= collide;
      if (rd0_en) s_d0 <= mem[addr0];
      if (rd1_en) s_d1 <= (collide && WRITE_FIRST) ? wr_word : mem[addr1];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk0) begin
        if (rst0) begin
          p_v0 <= 1'b0;
          p_v1 <= 1'b0;
          p_d0 <= '0;
          p_d1 <= '0;
        end else begin
          p_v0 <= s_v0;
          p_v1 <= s_v1;
          if (s_v0) p_d0 <= s_d0;
          if (s_v1) p_d1 <= s_d1;
        end
      end
    end else begin : g_lat1
      assign p_v0 = s_v0;
      assign p_v1 = s_v1;
      assign p_d0 = s_d0;
      assign p_d1 = s_d1;
    end
  endgenerate

  // Output registers hold the last read word; only the valids pulse.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0       <= '0;
      dout1       <= '0;
      dout0_valid <= 1'b0;
      dout1_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      dout0_valid <= p_v0;
      dout1_valid <= p_v1;
      collision   <= s_col;
      if (p_v0) dout0 <= p_d0;
      if (p_v1) dout1 <= p_d1;
    end
  end

endmodule
